// File: rtl/global_config_pkg.sv
// Global configuration shared across the frontend: ISA/address widths and
// the instruction-buffer entry type passed from the IFU to decode.
package global_config_pkg;

  typedef struct packed {
    int unsigned ILEN;
    int unsigned PLEN;
  } cfg_t;

  localparam cfg_t Cfg = '{ILEN: 32, PLEN: 32};

  localparam int unsigned IbufDepth = 8;

  typedef struct packed {
    logic [Cfg.PLEN-1:0] pc;
    logic [Cfg.ILEN-1:0] instr;
  } ibuf_entry_t;

  typedef struct packed {
    logic valid;
    logic ready;
  } handshake_t;

endpackage

// File: rtl/instr_buffer.sv
// IFU -> decode instruction FIFO. Wrap-bit pointers give full/empty for free;
// flush resets both pointers and wins over any same-cycle enqueue/dequeue.
module instr_buffer
  import global_config_pkg::*;
#(
  parameter cfg_t        Cfg   = global_config_pkg::Cfg,
  parameter int unsigned DEPTH = IbufDepth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  ibuf_entry_t              enq_entry_i,
  output logic                     deq_valid_o,
  input  logic                     deq_ready_i,
  output ibuf_entry_t              deq_entry_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  if ($bits(ibuf_entry_t) != Cfg.ILEN + Cfg.PLEN) begin : g_cfg_chk
    $error("ibuf_entry_t width does not match Cfg ILEN+PLEN");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("DEPTH must be a power of two >= 2");
  end

  ibuf_entry_t     mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            empty, full, enq_fire, deq_fire;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);

  // ready is a pure function of state: no combinational path from deq_ready_i
  assign enq_ready_o = !full;
  assign deq_valid_o = !empty;
  assign deq_entry_o = mem[rd_ptr[AW-1:0]];
  assign count_o     = wr_ptr - rd_ptr;

  assign enq_fire = enq_valid_i && enq_ready_o && !flush_i;
  assign deq_fire = deq_valid_o && deq_ready_i && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is intentionally left unreset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (enq_fire) mem[wr_ptr[AW-1:0]] <= enq_entry_i;
  end

endmodule
